pwm_ramp_gen: RTL

Downstream PWM stage for the drive motors: consumes the duty-cycle word and enable produced by the motor controller and generates the PWM waveform fed to the motor driver signal pins. Duty changes are applied only at frame boundaries and slew-limited per frame, giving soft start and soft stop on direction changes and stops. One instance drives all four motor signal lines.

---
 rtl/pwm_ramp_gen_if.sv | 20 ++
 rtl/pwm_ramp_gen.sv | 76 +++++++
 2 files changed

// File: rtl/pwm_ramp_gen_if.sv
// Duty/enable request from the motor controller and the resulting PWM drive/status.
interface pwm_ramp_gen_if;
  logic        en;
  logic [31:0] duty;
  logic        signal;
  logic [31:0] cur_duty;
  logic        at_target;
  logic        frame_start;
  logic [1:0]  state;

  modport master (
    output en, duty,
    input  signal, cur_duty, at_target, frame_start, state
  );

  modport slave (
    input  en, duty,
    output signal, cur_duty, at_target, frame_start, state
  );
endinterface

// File: rtl/pwm_ramp_gen.sv
// Frame-based PWM generator; duty is slew-limited to STEP per frame and only
// changes at the frame wrap, giving soft start/stop on the motor drive.
module pwm_ramp_gen #(
  parameter int unsigned PERIOD = 100000,
  parameter int unsigned STEP   = 1900
) (
  input  logic           clck,
  input  logic           reset,
  pwm_ramp_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam logic [31:0] PER  = 32'(PERIOD);
  localparam logic [31:0] LAST = 32'(PERIOD - 1);
  localparam logic [31:0] STP  = 32'(STEP);

  logic [31:0] cnt, cnt_nxt;
  logic [31:0] cur, cur_nxt;
  logic [31:0] tgt, tgt_nxt;
  logic        wrap;
  logic        sig;
  logic        fs;
  state_t      st;

  // Target is clamped to PERIOD so cur never exceeds it and cur+STP cannot wrap.
  always_comb begin
    wrap    = (cnt == LAST);
    cnt_nxt = wrap ? 32'd0 : cnt + 32'd1;
    tgt_nxt = 32'd0;
    if (bus.en)
      tgt_nxt = (bus.duty > PER) ? PER : bus.duty;
    if (tgt_nxt >= cur)
      cur_nxt = (tgt_nxt - cur <= STP) ? tgt_nxt : cur + STP;
    else
      cur_nxt = (cur - tgt_nxt <= STP) ? tgt_nxt : cur - STP;
  end

  always_ff @(posedge clck or negedge reset) begin
    if (!reset) begin
      cnt <= 32'd0;
      cur <= 32'd0;
      tgt <= 32'd0;
      sig <= 1'b0;
      fs  <= 1'b0;
      st  <= IDLE;
    end else begin
      cnt <= cnt_nxt;
      fs  <= wrap;
      if (wrap) begin
        cur <= cur_nxt;
        tgt <= tgt_nxt;
        // New duty applies on the cnt=0 cycle itself, so full duty never glitches low.
        sig <= (cur_nxt != 32'd0);
        if (cur_nxt < tgt_nxt)      st <= RAMP_UP;
        else if (cur_nxt > tgt_nxt) st <= RAMP_DOWN;
        else if (tgt_nxt == 32'd0)  st <= IDLE;
        else                        st <= HOLD;
      end else begin
        sig <= (cnt_nxt < cur);
      end
    end
  end

  assign bus.signal      = sig;
  assign bus.cur_duty    = cur;
  assign bus.at_target   = (cur == tgt);
  assign bus.frame_start = fs;
  assign bus.state       = st;

endmodule
